pipeline_issue_ctrl: RTL

//  Sequences one job of N beats into a fixed-latency Axiline training datapath built from

---
 rtl/pipeline_issue_ctrl.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/pipeline_issue_ctrl.sv
// pipeline_issue_ctrl
// Sequences one job of len beats into a fixed-latency datapath. It issues
// element indices and gates each issue on downstream credits. A {valid,last}
// delay line mirrors the datapath depth, and done pulses once the last beat
// has drained out of that line.
//
// Handshake: a beat is transferred on every cycle where o_issue_valid is 1.
// There is no ready input. Back-pressure comes only from the credit counter,
// and o_issue_valid is never raised without a free credit. o_issue_idx and
// o_issue_last are meaningful only while o_issue_valid is 1.
module pipeline_issue_ctrl #(
    parameter int LATENCY = 2,
    parameter int CNT_W   = 16,
    parameter int CREDITS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [CNT_W-1:0] i_len,
    input  logic             i_credit_return,
    output logic             o_busy,
    output logic             o_issue_valid,
    output logic [CNT_W-1:0] o_issue_idx,
    output logic             o_issue_last,
    output logic             o_out_valid,
    output logic             o_out_last,
    output logic             o_done,
    output logic             o_err,
    output logic [1:0]       o_state
);

    localparam int CRD_W = $clog2(CREDITS + 1);
    localparam logic [CRD_W-1:0] CRD_MAX = CREDITS[CRD_W-1:0];
    localparam logic [CRD_W-1:0] CRD_ONE = 1;
    localparam logic [CNT_W-1:0] IDX_ONE = 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_len;
    logic [CNT_W-1:0] r_idx;
    logic [CRD_W-1:0] r_credits;
    logic             r_err;

    logic w_busy;
    logic w_issue;
    logic w_issue_last;
    logic w_done;
    logic w_line_empty;
    logic w_credit_ovf;
    logic w_start_busy;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) w_next_state = (i_len != '0) ? S_ISSUE : S_DONE;
            end
            S_ISSUE: begin
                if (w_issue_last) w_next_state = S_DRAIN;
            end
            S_DRAIN: begin
                if (w_line_empty) w_next_state = S_DONE;
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Outputs decoded from registered state, index and credits only
    always_comb begin
        w_busy       = (r_state != S_IDLE);
        w_issue      = (r_state == S_ISSUE) && (r_credits != '0);
        w_issue_last = w_issue && (r_idx == (r_len - IDX_ONE));
        w_done       = (r_state == S_DONE);
    end

    // Job length latch and element index counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len <= '0;
            r_idx <= '0;
        end else if (r_state == S_IDLE && i_start) begin
            r_len <= i_len;
            r_idx <= '0;
        end else if (w_issue) begin
            r_idx <= r_idx + IDX_ONE;
        end
    end

    // A return at full credits with no issue this cycle is an overflow
    assign w_credit_ovf = i_credit_return && !w_issue && (r_credits == CRD_MAX);
    assign w_start_busy = i_start && w_busy;

    // Credit counter: issue consumes, return refills, saturating at CREDITS
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_credits <= CRD_MAX;
        end else begin
            case ({w_issue, i_credit_return})
                2'b10:   r_credits <= r_credits - CRD_ONE;
                2'b01:   if (r_credits != CRD_MAX) r_credits <= r_credits + CRD_ONE;
                default: r_credits <= r_credits;
            endcase
        end
    end

    // Error pulse, registered so it is clean for one full cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_err <= 1'b0;
        else     r_err <= w_credit_ovf || w_start_busy;
    end

    // The delay line mirrors the datapath depth. A zero-depth datapath is a wire,
    // so the line is always empty and DRAIN lasts exactly one cycle.
    generate
        if (LATENCY == 0) begin : g_no_delay
            assign o_out_valid  = w_issue;
            assign o_out_last   = w_issue_last;
            assign w_line_empty = 1'b1;
        end else begin : g_delay
            logic [LATENCY-1:0] r_dv;
            logic [LATENCY-1:0] r_dl;

            // Shift {valid,last} one stage per cycle; reset flushes in-flight beats
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_dv <= '0;
                    r_dl <= '0;
                end else begin
                    r_dv[0] <= w_issue;
                    r_dl[0] <= w_issue_last;
                    for (int i = 1; i < LATENCY; i++) begin
                        r_dv[i] <= r_dv[i-1];
                        r_dl[i] <= r_dl[i-1];
                    end
                end
            end

            assign o_out_valid  = r_dv[LATENCY-1];
            assign o_out_last   = r_dl[LATENCY-1];
            assign w_line_empty = ~|r_dv;
        end
    endgenerate

    assign o_busy        = w_busy;
    assign o_issue_valid = w_issue;
    assign o_issue_idx   = r_idx;
    assign o_issue_last  = w_issue_last;
    assign o_done        = w_done;
    assign o_err         = r_err;
    assign o_state       = r_state;

endmodule
